// File: rtl/store_narrow_if.sv
// Store request and data-memory port bundle for the store narrowing unit.
// Pure wiring; no latency of its own.
// Backpressure is carried by req_ready_o (request side); the memory side has none.
interface store_narrow_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [1:0]  size_i;
    logic        done_o;
    logic        err_o;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic        mem_rd_valid_i;
    logic [31:0] mem_rdata_i;
    logic        mem_wr_o;
    logic [31:0] mem_wdata_o;

    // Unit side: consumes requests and read data, drives memory strobes and status.
    modport slave (
        input  req_valid_i, addr_i, data_i, size_i, mem_rd_valid_i, mem_rdata_i,
        output req_ready_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
    );

    // Pipeline / memory side: the mirror image.
    modport master (
        output req_valid_i, addr_i, data_i, size_i, mem_rd_valid_i, mem_rdata_i,
        input  req_ready_o, done_o, err_o, mem_addr_o, mem_rd_o, mem_wr_o, mem_wdata_o
    );
endinterface

// File: rtl/store_narrow.sv
// Byte/halfword/word store into a word-wide memory without byte enables, via read-modify-write.
// Latency: word or error 1 cycle to done; byte/half 3 cycles plus read wait cycles.
// Backpressure: req_ready_o is high only in IDLE; one request in flight at a time.
module store_narrow #(
    parameter int TIMEOUT = 255
) (
    input logic           clk_i,
    input logic           rst_i,
    store_narrow_if.slave bus
);

    // Counter must hold TIMEOUT; never narrower than 8 bits.
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [31:0]   addr_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic [15:0]   data_q;
    logic [31:0]   wdata_q;
    logic          req_bad;
    logic          tim_hit;
    logic [31:0]   merged;

    // Reserved size or an address not aligned to the access size.
    always_comb begin
        req_bad = 1'b0;
        case (bus.size_i)
            2'b01:   req_bad = bus.addr_i[0];
            2'b10:   req_bad = (bus.addr_i[1:0] != 2'b00);
            2'b11:   req_bad = 1'b1;
            default: req_bad = 1'b0;
        endcase
    end

    assign tim_hit = (cnt_q == CW'(TIMEOUT));

    // Overlay the stored byte or halfword onto the word just read back.
    always_comb begin
        merged = bus.mem_rdata_i;
        if (size_q == 2'b00) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = data_q[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a read that arrives with the timeout still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    if (req_bad) begin
                        state_d = RESP;
                    end else if (bus.size_i == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: state_d = WAIT;
            WAIT: begin
                if (bus.mem_rd_valid_i) begin
                    state_d = WRITE;
                end else if (tim_hit) begin
                    state_d = RESP;
                end
            end
            WRITE:   state_d = IDLE;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, wait counter and write-data register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            data_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        addr_q <= {bus.addr_i[31:2], 2'b00};
                        lane_q <= bus.addr_i[1:0];
                        size_q <= bus.size_i;
                        data_q <= bus.data_i[15:0];
                        if (bus.size_i == 2'b10) begin
                            wdata_q <= bus.data_i;
                        end
                    end
                end
                READ: cnt_q <= '0;
                WAIT: begin
                    if (bus.mem_rd_valid_i) begin
                        wdata_q <= merged;
                    end else if (!tim_hit) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WRITE, RESP: addr_q <= '0;
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.mem_rd_o    = (state_q == READ);
    assign bus.mem_wr_o    = (state_q == WRITE);
    assign bus.done_o      = (state_q == WRITE) || (state_q == RESP);
    assign bus.err_o       = (state_q == RESP);
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: random stores against a byte-array reference model.
// Expected completions are queued at acceptance; a monitor checks every done_o pulse.
// Memory responder delays read data randomly, sometimes past the timeout.
module tb_store_narrow;

    localparam int TO = 4;

    typedef struct {
        int          cyc;
        bit          err;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          nrd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_i;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   wr_seen = 0;
    int   rd_cnt = 0;
    bit   prev_done = 0;

    int          cur_delay;
    logic [31:0] cur_rdata;
    bit          cur_junk;
    exp_t        exp_q[$];

    store_narrow_if bus ();

    store_narrow #(.TIMEOUT(TO)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what the memory word should become, and when done should appear.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] d,
                                   input logic [1:0] s, input int dly,
                                   input logic [31:0] mem, input int c);
        exp_t       e;
        logic [7:0] b[4];
        int         k;
        bit         bad;
        for (int i = 0; i < 4; i++) b[i] = mem[8*i +: 8];
        k   = int'(a % 4);
        bad = (s == 2'd3) || (s == 2'd1 && (a % 2) != 0) || (s == 2'd2 && (a % 4) != 0);
        e.addr  = a & 32'hFFFF_FFFC;
        e.wdata = 32'h0;
        if (bad) begin
            e.err = 1; e.wr = 0; e.nrd = 0; e.cyc = c + 1;
        end else if (s == 2'd2) begin
            e.err = 0; e.wr = 1; e.nrd = 0; e.cyc = c + 1; e.wdata = d;
        end else begin
            e.nrd = 1;
            if (dly > TO) begin
                e.err = 1; e.wr = 0; e.cyc = c + 3 + TO;
            end else begin
                e.err = 0; e.wr = 1; e.cyc = c + 3 + dly;
                if (s == 2'd0) begin
                    b[k] = d[7:0];
                end else begin
                    b[k & 2]       = d[7:0];
                    b[(k & 2) + 1] = d[15:8];
                end
                e.wdata = {b[3], b[2], b[1], b[0]};
            end
        end
        return e;
    endfunction

    // Call at #2 after a posedge; returns at #2 after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                         input int dly, input logic [31:0] rd, input bit junk, input bit push);
        int w = 0;
        while (!bus.req_ready_o && w < 200) begin
            @(posedge clk); #2;
            w++;
        end
        if (!bus.req_ready_o) begin
            chk("ready_wait", {31'b0, bus.req_ready_o}, 32'd1);
            return;
        end
        cur_delay = dly;
        cur_rdata = rd;
        cur_junk  = junk;
        bus.req_valid_i = 1'b1;
        bus.addr_i      = a;
        bus.data_i      = d;
        bus.size_i      = s;
        @(negedge clk);
        if (push) exp_q.push_back(model(a, d, s, dly, rd, cyc));
        @(posedge clk); #2;
        bus.req_valid_i = 1'b0;
        bus.addr_i      = $urandom;
        bus.data_i      = $urandom;
        bus.size_i      = 2'($urandom_range(0, 3));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_ready", {31'b0, bus.req_ready_o}, 32'd1);
        chk("rst_done",  {31'b0, bus.done_o},      32'd0);
        chk("rst_err",   {31'b0, bus.err_o},       32'd0);
        chk("rst_rd",    {31'b0, bus.mem_rd_o},    32'd0);
        chk("rst_wr",    {31'b0, bus.mem_wr_o},    32'd0);
        chk("rst_addr",  bus.mem_addr_o,           32'd0);
        chk("rst_wdata", bus.mem_wdata_o,          32'd0);
    endtask

    // Memory responder: read data after a programmed number of WAIT cycles.
    initial begin
        int          pend_cnt;
        bit          pend;
        logic [31:0] pend_dat;
        pend = 0;
        pend_cnt = 0;
        pend_dat = '0;
        bus.mem_rd_valid_i = 1'b0;
        bus.mem_rdata_i    = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_rd_valid_i = 1'b0;
            bus.mem_rdata_i    = $urandom;
            if (bus.mem_rd_o) begin
                pend     = (cur_delay < 100);
                pend_cnt = cur_delay;
                pend_dat = cur_rdata;
                if (cur_junk) bus.mem_rd_valid_i = 1'b1;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    bus.mem_rd_valid_i = 1'b1;
                    bus.mem_rdata_i    = pend_dat;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end
        end
    end

    // Monitor: compares every completion against the scoreboard.
    always @(negedge clk) begin
        if (rst_i) begin
            rd_cnt    = 0;
            prev_done = 0;
        end else begin
            if (prev_done) chk("ready_after_done", {31'b0, bus.req_ready_o}, 32'd1);
            if (bus.req_ready_o) chk("idle_addr", bus.mem_addr_o, 32'd0);
            if (bus.mem_rd_o) rd_cnt++;
            if (bus.mem_wr_o) begin
                wr_seen++;
                chk("wr_has_done", {31'b0, bus.done_o}, 32'd1);
            end
            if (bus.err_o) chk("err_has_done", {31'b0, bus.done_o}, 32'd1);
            if (bus.done_o) begin
                chk("done_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("err",        {31'b0, bus.err_o},    {31'b0, e.err});
                    chk("wr",         {31'b0, bus.mem_wr_o}, {31'b0, e.wr});
                    chk("rd_count",   rd_cnt,                e.nrd);
                    chk("mem_addr",   bus.mem_addr_o,        e.addr);
                    if (e.wr) chk("wdata", bus.mem_wdata_o, e.wdata);
                end
                rd_cnt = 0;
            end
            prev_done = bus.done_o;
        end
    end

    initial begin
        int w0;
        int w;
        rst_i = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.addr_i = '0;
        bus.data_i = '0;
        bus.size_i = '0;
        cur_delay = 0;
        cur_rdata = '0;
        cur_junk  = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        #1 rst_i = 1'b0;
        @(posedge clk); #2;

        // Directed cases.
        issue(32'h0000_0010, 32'hDEAD_BEEF, 2'd2, 0,   32'h0,         0, 1);
        issue(32'h0000_0013, 32'h0000_00AB, 2'd0, 0,   32'h1122_3344, 0, 1);
        issue(32'h0000_0006, 32'hFFFF_CAFE, 2'd1, 3,   32'h1122_3344, 1, 1);
        issue(32'h1234_5671, 32'h5555_AAAA, 2'd1, 0,   32'h0,         0, 1);
        issue(32'h0000_0020, 32'h5555_AAAA, 2'd3, 0,   32'h0,         0, 1);
        issue(32'h0000_0102, 32'h7777_8888, 2'd2, 0,   32'h0,         0, 1);
        issue(32'h0000_0041, 32'h0000_0099, 2'd0, 999, 32'h0,         0, 1);
        issue(32'h0000_0042, 32'h0000_1234, 2'd1, TO,  32'hCAFE_F00D, 0, 1);

        // Random stores, random gaps, random read latency around the timeout.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            s = 2'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #2;
            end
            issue(a, $urandom, s, $urandom_range(0, 6), $urandom, bit'($urandom_range(0, 1)), 1);
        end

        // Reset in the first WAIT cycle aborts the store silently.
        issue(32'h0000_0081, 32'h0000_00EE, 2'd0, 3, 32'hAAAA_BBBB, 0, 0);
        @(posedge clk); #2;
        rst_i = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs();
        rst_i = 1'b0;
        w0 = wr_seen;
        repeat (10) begin
            @(posedge clk); #2;
        end
        chk("no_wr_after_reset", wr_seen, w0);

        // Recovery after reset.
        issue(32'h0000_0084, 32'h0BAD_F00D, 2'd2, 0, 32'h0, 0, 1);
        issue(32'h0000_0086, 32'h0000_BEEF, 2'd1, 1, 32'h0123_4567, 0, 1);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk); #2;
            w++;
        end
        chk("drain_pending", exp_q.size(), 32'd0);
        @(posedge clk); #2;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/store_narrow.md
# store_narrow

Store-path narrowing unit for the MIPS datapath: the write-side counterpart of load sign extension. It takes a 32-bit register value and stores its low byte, low halfword or full word into a word-wide data memory that has no byte enables, using a read-modify-write sequence. It sits between the pipeline's memory stage and the data memory port, and reports completion or error per request.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in WAIT for read data before the request is aborted with an error.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  store request present.
- req_ready_o  out  1  unit can accept a request (high only in IDLE).
- addr_i  in  32  byte address of the store.
- data_i  in  32  register data; low bits are stored.
- size_i  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  one-cycle error pulse, always coincident with done_o.
- mem_addr_o  out  32  word address {addr[31:2],2'b00}.
- mem_rd_o  out  1  one-cycle memory read request.
- mem_rd_valid_i  in  1  read data valid.
- mem_rdata_i  in  32  read data.
- mem_wr_o  out  1  one-cycle memory write strobe.
- mem_wdata_o  out  32  merged write data.

## Operation
- Accept on a rising edge with req_valid_i && req_ready_o; latch addr_i, data_i, size_i. Inputs are don't-care after acceptance.
- Error check at acceptance: size 11; halfword with addr[0]=1; word with addr[1:0]≠00. On error, go to RESP, pulse done_o+err_o, issue no memory access.
- States: IDLE, READ, WAIT, WRITE, RESP.
  - IDLE → WRITE for a valid word store, → READ for a valid byte/half store, → RESP on error.
  - READ: mem_rd_o=1 for exactly one cycle, then → WAIT.
  - WAIT: on mem_rd_valid_i, capture mem_rdata_i and go → WRITE. If the cycle counter reaches TIMEOUT first, go → RESP with error and no write.
  - WRITE: mem_wr_o=1 and done_o=1 for one cycle, then → IDLE.
  - RESP: done_o=1 and err_o=1 for one cycle, then → IDLE.
- Merge is little-endian, with lane 0 = bits 7:0.
  - Byte at lane k=addr[1:0]: bits [8k+7:8k] ← data[7:0]; the other bits come from the captured read data.
  - Half at h=addr[1]: bits [16h+15:16h] ← data[15:0].
  - Word: mem_wdata_o = data; no read is issued.
- mem_addr_o is held constant from acceptance until return to IDLE. Its value is 0 in IDLE.
- mem_rd_valid_i is ignored in every state except WAIT. Data arriving in the READ cycle itself is not captured.
- The WAIT counter is 8+ bits wide (sized to hold TIMEOUT). It clears on entry to WAIT and saturates; it is not free-running.

## Timing
- Reset values: req_ready_o=1 (IDLE); done_o, err_o, mem_rd_o, mem_wr_o = 0; mem_addr_o, mem_wdata_o = 0; the counter is 0.
- All outputs are driven from registers or decoded from the state only. There are no combinational paths from inputs to outputs.
- Latency, with acceptance at edge t:
  - Word store: mem_wr_o and done_o in cycle t+1.
  - Error: done_o and err_o in cycle t+1.
  - Byte/half store: mem_rd_o in cycle t+1; earliest WAIT cycle t+2 (valid sampled there); mem_wr_o and done_o in cycle t+3 + extra wait cycles.
- Back-to-back: req_ready_o returns high in the cycle after done_o. The minimum issue interval is 2 cycles for word stores and 4 cycles for sub-word stores.
- Reset asserted mid-operation: on the next edge, return to IDLE with all strobes low. No write is issued and no done_o is produced for the aborted request.
- Timeout: with mem_rd_valid_i never asserted, done_o and err_o pulse TIMEOUT+1 cycles after the first WAIT cycle.

## Test plan
- Word store, addr=0x0000_0010, data=0xDEAD_BEEF: no mem_rd_o; mem_wr_o at t+1 with mem_addr_o=0x10 and wdata=0xDEAD_BEEF; done_o=1, err_o=0.
- Byte store, addr=0x0000_0013, data=0x0000_00AB, read returns 0x1122_3344 in the first WAIT cycle: mem_rd_o at t+1; mem_wr_o at t+3 with wdata=0xAB22_3344.
- Half store, addr=0x0000_0006, data=0xFFFF_CAFE, read returns 0x1122_3344 after 3 wait cycles: wdata=0xCAFE_3344; mem_wr_o at t+6.
- Misaligned half at addr=0x...1, then size=11: each gives done_o+err_o at t+1, with no mem_rd_o and no mem_wr_o.
- Timeout with TIMEOUT=4 and read data withheld: done_o+err_o after 5 WAIT cycles; mem_wr_o is never asserted; req_ready_o is high on the next cycle.
- Reset asserted in the WAIT cycle: on the next edge all outputs are at reset values; a later mem_rd_valid_i is ignored and no mem_wr_o occurs.
